// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
// VGA timing and test-pattern generator for the pixel-clock domain. Video
// timing is set by parameters; one of four patterns (solid white, colour bars,
// checkerboard, gradient) is selected at run time and only switches at a frame
// boundary. A wrapping frame counter and a frame-start strobe are provided for
// downstream logic. Every output is registered one cycle behind the counters.
//
// Ports
//   clk          pixel clock
//   rst          asynchronous active-high reset
//   pattern_sel  requested pattern (0 solid, 1 bars, 2 checker, 3 gradient)
//   vga_red/grn/blu  pixel colour, COLOR_WIDTH bits each, 0 outside visible area
//   vga_hsync/vsync  sync pulses at the configured polarity
//   vga_de       high for visible pixels
//   frame_cnt    completed-frame count, wraps 255 -> 0
//   frame_start  one-cycle pulse with output pixel (0,0)
// -----------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int unsigned COLOR_WIDTH   = 4,
    parameter int unsigned H_VISIBLE     = 640,
    parameter int unsigned H_FP          = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BP          = 48,
    parameter int unsigned V_VISIBLE     = 480,
    parameter int unsigned V_FP          = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BP          = 33,
    parameter bit          H_SYNC_POL    = 1'b0,
    parameter bit          V_SYNC_POL    = 1'b0,
    parameter int unsigned CHECK_LOG2    = 5,
    parameter int unsigned PATTERN_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             pattern_sel,
    output logic [COLOR_WIDTH-1:0] vga_red,
    output logic [COLOR_WIDTH-1:0] vga_grn,
    output logic [COLOR_WIDTH-1:0] vga_blu,
    output logic                   vga_hsync,
    output logic                   vga_vsync,
    output logic                   vga_de,
    output logic [7:0]             frame_cnt,
    output logic                   frame_start
);

    localparam int unsigned H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W        = $clog2(H_TOTAL);
    localparam int unsigned V_W        = $clog2(V_TOTAL);
    localparam int unsigned H_SYNC_BEG = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

    // Bar width; guarded so very narrow test modes still get a usable counter.
    localparam int unsigned BAR_W      = (H_VISIBLE >= 8) ? (H_VISIBLE / 8) : 1;
    localparam int unsigned BAR_PIX_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    // Counters are widened before shifting so the checker/gradient bit
    // selects stay in range even when the counters are narrow.
    localparam int unsigned SEL_W      = CHECK_LOG2 + COLOR_WIDTH;
    localparam int unsigned H_SH_W     = H_W + SEL_W;
    localparam int unsigned V_SH_W     = V_W + SEL_W;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_GRAD  = 2'd3;

    localparam logic [COLOR_WIDTH-1:0] FULL = {COLOR_WIDTH{1'b1}};

    logic [H_W-1:0]         h_cnt;
    logic [V_W-1:0]         v_cnt;
    logic [7:0]             frame_q;
    logic [1:0]             pat_q;
    logic [BAR_PIX_W-1:0]   bar_pix;
    logic [2:0]             bar_idx;

    logic                   line_end_c;
    logic                   frame_end_c;
    logic                   visible_c;
    logic                   hsync_act_c;
    logic                   vsync_act_c;
    logic                   frame_start_c;
    logic [H_SH_W-1:0]      h_sh_c;
    logic [V_SH_W-1:0]      v_sh_c;
    logic [COLOR_WIDTH-1:0] red_c;
    logic [COLOR_WIDTH-1:0] grn_c;
    logic [COLOR_WIDTH-1:0] blu_c;

    // Position decode for the current counter state.
    always_comb begin
        line_end_c    = (32'(h_cnt) == (H_TOTAL - 1));
        frame_end_c   = line_end_c && (32'(v_cnt) == (V_TOTAL - 1));
        visible_c     = (32'(h_cnt) < H_VISIBLE) && (32'(v_cnt) < V_VISIBLE);
        hsync_act_c   = (32'(h_cnt) >= H_SYNC_BEG) && (32'(h_cnt) < H_SYNC_END);
        vsync_act_c   = (32'(v_cnt) >= V_SYNC_BEG) && (32'(v_cnt) < V_SYNC_END);
        frame_start_c = (h_cnt == '0) && (v_cnt == '0);
        h_sh_c        = H_SH_W'(h_cnt) >> CHECK_LOG2;
        v_sh_c        = V_SH_W'(v_cnt) >> CHECK_LOG2;
    end

    // Pixel colour for the current counter state; blank outside visible area.
    always_comb begin
        red_c = '0;
        grn_c = '0;
        blu_c = '0;
        if (visible_c) begin
            case (pat_q)
                PAT_SOLID: begin
                    red_c = FULL;
                    grn_c = FULL;
                    blu_c = FULL;
                end
                PAT_BARS: begin
                    red_c = bar_idx[2] ? FULL : '0;
                    grn_c = bar_idx[1] ? FULL : '0;
                    blu_c = bar_idx[0] ? FULL : '0;
                end
                PAT_CHECK: begin
                    if (h_sh_c[0] ^ v_sh_c[0]) begin
                        red_c = FULL;
                        grn_c = FULL;
                        blu_c = FULL;
                    end
                end
                PAT_GRAD: begin
                    red_c = COLOR_WIDTH'(h_sh_c);
                    grn_c = COLOR_WIDTH'(v_sh_c);
                    blu_c = frame_q[7 -: COLOR_WIDTH];
                end
                default: begin
                    red_c = '0;
                    grn_c = '0;
                    blu_c = '0;
                end
            endcase
        end
    end

    // Horizontal / vertical position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end_c) begin
            h_cnt <= '0;
            v_cnt <= frame_end_c ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Pattern and frame count only change at frame end, so a frame is never
    // drawn with a mix of patterns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= 2'(PATTERN_RESET);
            frame_q <= '0;
        end else if (frame_end_c) begin
            pat_q   <= pattern_sel;
            frame_q <= frame_q + 8'd1;
        end
    end

    // Bar index: steps every BAR_W pixels, saturates at 7, restarts each line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (line_end_c) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (32'(bar_pix) == (BAR_W - 1)) begin
            bar_pix <= '0;
            if (bar_idx != 3'd7) begin
                bar_idx <= bar_idx + 3'd1;
            end
        end else begin
            bar_pix <= bar_pix + 1'b1;
        end
    end

    // Output stage: one register between the counter state and every output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_red     <= '0;
            vga_grn     <= '0;
            vga_blu     <= '0;
            vga_de      <= 1'b0;
            vga_hsync   <= ~H_SYNC_POL;
            vga_vsync   <= ~V_SYNC_POL;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            vga_red     <= red_c;
            vga_grn     <= grn_c;
            vga_blu     <= blu_c;
            vga_de      <= visible_c;
            vga_hsync   <= hsync_act_c ? H_SYNC_POL : ~H_SYNC_POL;
            vga_vsync   <= vsync_act_c ? V_SYNC_POL : ~V_SYNC_POL;
            frame_start <= frame_start_c;
            frame_cnt   <= frame_q;
        end
    end

endmodule
